// File: rtl/sprite_ram_arbiter.sv
// Round-robin arbiter that shares one synchronous sprite frame RAM read port between NUM_REQ renderers.
// Define SPRITE_ARB_FIXED_PRIO_EN to use fixed priority (requester 0 highest) instead of round-robin.
module sprite_ram_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 400,
  parameter int RAM_LATENCY = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [ADDR_W-1:0]         ram_read_address,
  input  logic [DATA_W-1:0]         ram_data_in,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One tag stage for the address register plus RAM_LATENCY stages matching the RAM.
  localparam int STAGES = RAM_LATENCY + 1;

  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_cand;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic               w_oor;

  logic [ADDR_W-1:0]  r_addr;
  logic [NUM_REQ-1:0] r_tag_oh [STAGES];
  logic [STAGES-1:0]  r_tag_err;

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]   r_rr_ptr;
`endif

  always_comb begin
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      w_cand = PTR_W'(off);
`else
      w_cand = PTR_W'((int'(r_rr_ptr) + off) % NUM_REQ);
`endif
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    if (Reset) begin
      w_found = 1'b0;
    end
    w_grant = '0;
    if (w_found) begin
      w_grant[w_idx] = 1'b1;
    end
  end

  always_comb begin
    w_gnt_addr = req_addr[w_idx*ADDR_W +: ADDR_W];
    w_oor      = (32'(w_gnt_addr) >= DEPTH);
  end

  assign req_grant = w_grant;

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
    end
  end
`endif

  // Out-of-range grants leave the address untouched so the RAM sees no new access.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr    <= '0;
      r_tag_err <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_tag_oh[s] <= '0;
      end
    end else begin
      if (w_found && !w_oor) begin
        r_addr <= w_gnt_addr;
      end
      r_tag_oh[0]  <= w_grant;
      r_tag_err[0] <= w_found & w_oor;
      for (int s = 1; s < STAGES; s++) begin
        r_tag_oh[s]  <= r_tag_oh[s-1];
        r_tag_err[s] <= r_tag_err[s-1];
      end
    end
  end

  assign ram_read_address = r_addr;

  // Data is masked when idle or on error so the shared pixel bus stays zero.
  always_comb begin
    resp_valid = r_tag_oh[STAGES-1];
    resp_err   = r_tag_err[STAGES-1] & (|r_tag_oh[STAGES-1]);
    resp_data  = ((|r_tag_oh[STAGES-1]) && !r_tag_err[STAGES-1]) ? ram_data_in : '0;
  end

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Directed bench for sprite_ram_arbiter with a 1-cycle behavioural frame RAM whose contents are a fixed address hash.
module tb_sprite_ram_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 24;

  logic                      Clk = 1'b0;
  logic                      Reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_grant;
  logic [ADDR_W-1:0]         ram_read_address;
  logic [DATA_W-1:0]         ram_data_in;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;

  int checks = 0;
  int errors = 0;

  sprite_ram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(400), .RAM_LATENCY(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_grant(req_grant), .ram_read_address(ram_read_address), .ram_data_in(ram_data_in),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = 32'h00A5_0000 ^ (32'(a) * 32'h0001_0307);
    return t[DATA_W-1:0];
  endfunction

  always @(posedge Clk) ram_data_in <= pix(ram_read_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_addr(input int a0, input int a1, input int a2);
    req_addr = {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic chk_resp(input string tag, input logic [2:0] v, input logic e, input logic [23:0] d);
    chk({tag, "_valid"}, 32'(resp_valid), 32'(v));
    chk({tag, "_err"}, 32'(resp_err), 32'(e));
    chk({tag, "_data"}, 32'(resp_data), 32'(d));
  endtask

  initial begin
    Reset = 1'b1;
    req_valid = 3'b111;
    set_addr(0, 0, 0);
    ram_data_in = '0;
    @(negedge Clk);
    chk("grant_in_reset", 32'(req_grant), 32'h0);
    next_cycle();
    next_cycle();
    req_valid = 3'b000;
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_addr", 32'(ram_read_address), 32'd0);
    chk_resp("rst", 3'b000, 1'b0, 24'h0);

    // Single read of address 5 by requester 0.
    next_cycle();
    req_valid = 3'b001;
    set_addr(5, 0, 0);
    @(negedge Clk);
    chk("t1_grant", 32'(req_grant), 32'h1);
    next_cycle();
    req_valid = 3'b000;
    @(negedge Clk);
    chk("t1_grant_idle", 32'(req_grant), 32'h0);
    chk("t1_addr", 32'(ram_read_address), 32'd5);
    chk("t1_early_valid", 32'(resp_valid), 32'h0);
    next_cycle();
    @(negedge Clk);
    chk_resp("t1_resp", 3'b001, 1'b0, pix(10'd5));

`ifndef SPRITE_ARB_FIXED_PRIO_EN
    next_cycle();
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;

    // All three requesting for six cycles, then two drain cycles.
    set_addr(10, 20, 30);
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 3'b111 : 3'b000;
      @(negedge Clk);
      chk($sformatf("t2_grant%0d", k), 32'(req_grant), (k < 6) ? (32'h1 << (k % 3)) : 32'h0);
      if (k >= 1 && k <= 6) chk($sformatf("t2_addr%0d", k), 32'(ram_read_address), 32'(10 * ((k - 1) % 3 + 1)));
      if (k >= 2) chk_resp($sformatf("t2_resp%0d", k), 3'(3'b001 << ((k - 2) % 3)), 1'b0,
                           pix(ADDR_W'(10 * ((k - 2) % 3 + 1))));
      next_cycle();
    end

    // rr_ptr=0 here; one grant to 0 moves it to 1, then 101 must pick requester 2 first.
    set_addr(7, 3, 9);
    req_valid = 3'b001;
    @(negedge Clk);
    chk("t3_grant0", 32'(req_grant), 32'h1);
    next_cycle();
    req_valid = 3'b101;
    @(negedge Clk);
    chk("t3_grant1", 32'(req_grant), 32'h4);
    next_cycle();
    req_valid = 3'b001;
    @(negedge Clk);
    chk("t3_grant2", 32'(req_grant), 32'h1);
    chk_resp("t3_resp2", 3'b001, 1'b0, pix(10'd7));
    next_cycle();
    req_valid = 3'b111;
    @(negedge Clk);
    chk("t3_ptr_is_1", 32'(req_grant), 32'h2);
    chk_resp("t3_resp3", 3'b100, 1'b0, pix(10'd9));
    next_cycle();
    req_valid = 3'b000;
    @(negedge Clk);
    chk_resp("t3_resp4", 3'b001, 1'b0, pix(10'd7));

    // Out-of-range read by requester 1, followed by an in-range read by requester 2.
    next_cycle();
    set_addr(7, 400, 44);
    req_valid = 3'b010;
    @(negedge Clk);
    chk("t4_grant_oor", 32'(req_grant), 32'h2);
    chk("t4_addr_before", 32'(ram_read_address), 32'd3);
    chk_resp("t3_resp5", 3'b010, 1'b0, pix(10'd3));
    next_cycle();
    req_valid = 3'b100;
    @(negedge Clk);
    chk("t4_grant2", 32'(req_grant), 32'h4);
    chk("t4_addr_kept", 32'(ram_read_address), 32'd3);
    chk("t4_idle_valid", 32'(resp_valid), 32'h0);
    next_cycle();
    req_valid = 3'b000;
    @(negedge Clk);
    chk_resp("t4_resp_oor", 3'b010, 1'b1, 24'h0);
    chk("t4_addr_new", 32'(ram_read_address), 32'd44);
    next_cycle();
    @(negedge Clk);
    chk_resp("t4_resp_ok", 3'b100, 1'b0, pix(10'd44));

    // Reset between grant and response drops the response and rewinds rr_ptr.
    next_cycle();
    req_valid = 3'b001;
    @(negedge Clk);
    chk("t5_grant", 32'(req_grant), 32'h1);
    next_cycle();
    req_valid = 3'b000;
    Reset = 1'b1;
    @(negedge Clk);
    chk("t5_grant_rst", 32'(req_grant), 32'h0);
    next_cycle();
    Reset = 1'b0;
    req_valid = 3'b011;
    @(negedge Clk);
    chk_resp("t5_dropped", 3'b000, 1'b0, 24'h0);
    chk("t5_addr_rst", 32'(ram_read_address), 32'd0);
    chk("t5_ptr_rst", 32'(req_grant), 32'h1);
    next_cycle();
    req_valid = 3'b000;
    @(negedge Clk);
    chk("t5_addr", 32'(ram_read_address), 32'd7);
    chk("t5_no_valid", 32'(resp_valid), 32'h0);
    next_cycle();
    @(negedge Clk);
    chk_resp("t5_resp", 3'b001, 1'b0, pix(10'd7));
`else
    // Fixed priority: requester 0 wins every cycle while all three request.
    next_cycle();
    set_addr(10, 20, 30);
    req_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk($sformatf("fp_grant%0d", k), 32'(req_grant), 32'h1);
      if (k >= 2) chk_resp($sformatf("fp_resp%0d", k), 3'b001, 1'b0, pix(10'd10));
      next_cycle();
    end
    req_valid = 3'b000;
`endif

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
